activation_lookup: RTL and testbench

ACTIVATION_LOOKUP -- requirements
Module: activation_lookup

---
 rtl/activation_lookup.sv | 90 +++++++++
 tb/tb_activation_lookup.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/activation_lookup.sv
// Activation-table lookup: shift and clamp a signed weighted sum into an
// offset-binary table address, read the synchronous table, and hand the result downstream.
module activation_lookup #(
    parameter int SUM_WIDTH  = 24,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SUM_WIDTH-1:0]  in_sum,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   rom_addr_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic                    out_sat_reg;

    logic signed [SUM_WIDTH-1:0]   shifted;
    logic [SUM_WIDTH-ADDR_WIDTH:0] upper;
    logic                          fits;
    logic [ADDR_WIDTH-1:0]         addr_next;
    logic                          sat_next;

    assign shifted = $signed(in_sum) >>> SHIFT;

    // The shifted value fits the table range exactly when every bit above the
    // address sign bit is a copy of it.
    assign upper = shifted[SUM_WIDTH-1:ADDR_WIDTH-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
        addr_next = '0;
        sat_next  = ~fits;
        if (fits) begin
            // Flipping the sign bit turns two's complement into offset binary.
            addr_next = {~shifted[ADDR_WIDTH-1], shifted[ADDR_WIDTH-2:0]};
        end else if (shifted[SUM_WIDTH-1]) begin
            addr_next = '0;
        end else begin
            addr_next = '1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rom_addr_reg <= '0;
            out_sat_reg  <= 1'b0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                rom_addr_reg <= addr_next;
                out_sat_reg  <= sat_next;
            end
            if (state_reg == WAIT) begin
                out_data_reg <= rom_q;
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign rom_addr  = rom_addr_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_activation_lookup.sv
// Bench for activation_lookup: directed vector table, randomized sums against
// an arithmetic reference model, stall, mid-transaction reset and streaming sequences.
module tb_activation_lookup;

    localparam int SW = 24;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int SH = 6;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sum;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;

    int checks = 0;
    int errors = 0;

    activation_lookup #(
        .SUM_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbitrary but address-dependent table contents.
    function automatic logic [7:0] tbl(input int addr);
        logic [13:0] a;
        a = addr[13:0];
        return a[7:0] ^ a[13:6] ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_q <= tbl(int'(rom_addr));

    // Reference: floor-divide by 2^SHIFT, clamp, then add the midpoint offset.
    function automatic void model(input logic [SW-1:0] sum, output int addr, output bit sat);
        longint v, s, lo, hi;
        v  = longint'($signed(sum));
        lo = -(longint'(1) << (AW - 1));
        hi = (longint'(1) << (AW - 1)) - 1;
        if (v >= 0) s = v / (longint'(1) << SH);
        else        s = -((-v + (longint'(1) << SH) - 1) / (longint'(1) << SH));
        sat = 1'b0;
        if (s > hi) begin s = hi; sat = 1'b1; end
        if (s < lo) begin s = lo; sat = 1'b1; end
        addr = int'(s - lo);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic do_txn(input logic [SW-1:0] sum, input int exp_addr, input bit exp_sat,
                          input int hold, input string tag);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        in_sum    = sum;
        out_ready = (hold == 0);
        @(negedge clk);                      // ISSUE
        in_sum = ~sum;                       // in_valid stays high but must be ignored
        chk({tag, ".rom_addr"}, rom_addr, exp_addr);
        chk({tag, ".out_sat"}, out_sat, exp_sat);
        chk({tag, ".busy"}, {in_ready, out_valid}, 0);
        @(negedge clk);                      // WAIT
        chk({tag, ".early_valid"}, out_valid, 0);
        @(negedge clk);                      // DONE
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".out_data"}, out_data, tbl(exp_addr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".stall"}, {out_valid, in_ready, out_data, out_sat, rom_addr},
                {1'b1, 1'b0, tbl(exp_addr), exp_sat, 14'(exp_addr)});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".back_idle"}, {in_ready, out_valid}, 2'b10);
        out_ready = 1'b0;
        $display("txn %s sum=0x%06h addr=0x%04h sat=%0d data=0x%02h", tag, sum, rom_addr,
                 out_sat, out_data);
    endtask

    typedef struct {
        logic [SW-1:0] sum;
        int            addr;
        bit            sat;
        int            hold;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          a;
        bit          s;
        logic [SW-1:0] rs;
        logic [SW-1:0] stream_sums[6];
        int          exp_q[$];
        int          results;
        int          last_acc;
        int          k;

        vecs[0]  = '{24'h000000, 'h2000, 1'b0, 0};
        vecs[1]  = '{24'd64,     'h2001, 1'b0, 0};
        vecs[2]  = '{24'hFFFFFF, 'h1FFF, 1'b0, 1};
        vecs[3]  = '{24'h7FFFFF, 'h3FFF, 1'b1, 0};
        vecs[4]  = '{24'h800000, 'h0000, 1'b1, 2};
        vecs[5]  = '{24'd63,     'h2000, 1'b0, 0};
        vecs[6]  = '{24'hFFFFC0, 'h1FFF, 1'b0, 0};
        vecs[7]  = '{24'd524224, 'h3FFF, 1'b0, 0};
        vecs[8]  = '{24'd524288, 'h3FFF, 1'b1, 0};
        vecs[9]  = '{24'hF80000, 'h0000, 1'b0, 0};
        vecs[10] = '{24'hF7FFFF, 'h0000, 1'b1, 0};
        vecs[11] = '{24'h000FC0, 'h203F, 1'b0, 10};

        rst = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
        #3;
        chk("reset_state", {in_ready, out_valid, out_sat, out_data, rom_addr},
            {1'b1, 1'b0, 1'b0, 8'h00, 14'h0000});
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) do_txn(vecs[i].sum, vecs[i].addr, vecs[i].sat, vecs[i].hold,
                                 $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) rs = SW'($urandom);
            else rs = SW'(int'($urandom_range(1100000, 0)) - 550000);
            model(rs, a, s);
            do_txn(rs, a, s, int'($urandom_range(3, 0)), $sformatf("rnd%0d", i));
        end

        // Asynchronous reset while in WAIT, away from any clock edge.
        in_valid = 1'b1; in_sum = 24'h7FFFFF;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("rst.pre_sat", out_sat, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst.async", {in_ready, out_valid, out_sat, out_data, rom_addr},
            {1'b1, 1'b0, 1'b0, 8'h00, 14'h0000});
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst.no_result", {in_ready, out_valid}, 2'b10);
        end
        out_ready = 1'b0;
        $display("txn rst_mid_wait abandoned");

        // Streaming with in_valid held high: one accept every 4 cycles, in order.
        foreach (stream_sums[i]) stream_sums[i] = SW'($urandom);
        results = 0; last_acc = -1; k = 0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && results < 6; cyc++) begin
            if (out_valid) begin
                chk("stream.order", out_data, (exp_q.size() > 0) ? tbl(exp_q[0]) : -1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                results++;
                $display("txn stream result %0d data=0x%02h", results, out_data);
            end
            if (in_ready && k < 6) begin
                if (last_acc >= 0) chk("stream.spacing", cyc - last_acc, 4);
                last_acc = cyc;
                in_valid = 1'b1;
                in_sum   = stream_sums[k];
                model(stream_sums[k], a, s);
                exp_q.push_back(a);
                k++;
            end else if (k >= 6) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream.count", results, 6);
        in_valid = 1'b0; out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
